mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory-access stage directly downstream of the EX stage in the unpipelined RISC-V core.
- Consumes the EX result (address or ALU value), the store data and the forwarded control signals (su, whb, wos, opcode, PC_4, immOut).
- Performs loads and stores over a req/ack data-memory bus.
- Aligns and extends load data, then hands one selected write-back value to the WB stage.

Parameters:
- AW, 32, data-memory address width (low AW bits of result drive dmem_addr).
- LOAD_OP, 7'b0000011, opcode value that marks a load.
- STORE_OP, 7'b0100011, opcode value that marks a store.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- in_valid  in  1  EX outputs valid this cycle
- in_ready  out  1  stage can accept (IDLE only)
- result  in  32  ALU result / effective address
- Data_store  in  32  store data (rs2)
- immOut  in  32  immediate, write-back candidate
- PC_4  in  32  PC+4, write-back candidate
- opcode  in  7  instruction opcode
- su  in  1  1 = sign-extend load, 0 = zero-extend
- whb  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word
- wos  in  2  write-back select: 00 result, 01 load data, 10 PC_4, 11 immOut
- dmem_req  out  1  memory request, held until ack
- dmem_we  out  1  1 = write
- dmem_addr  out  AW  word-aligned address ({result[AW-1:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ack  in  1  request complete; dmem_rdata valid in same cycle for reads
- dmem_rdata  in  32  read word
- wb_valid  out  1  one-cycle pulse, wb_data valid
- wb_data  out  32  selected write-back value
- misalign  out  1  one-cycle pulse with wb_valid when the access was misaligned (see Optional Feature)

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; in_ready=1; dmem_req=0; dmem_we=0; dmem_addr=0; dmem_wdata=0; dmem_be=0; wb_valid=0; wb_data=0; misalign=0.
- Capture: in IDLE with in_valid=1, register all inputs at the clock edge.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE + in_valid + load/store opcode -> ACCESS.
  - IDLE + in_valid + any other opcode -> RESP.
  - ACCESS + dmem_ack -> RESP; read data is captured in the same edge.
  - RESP -> IDLE unconditionally; wb_valid=1 for exactly this one cycle.
- in_ready=1 only in IDLE.
- Latency:
  - Non-memory op accepted at edge N: wb_valid high in the cycle after edge N.
  - Memory op: dmem_req high from the cycle after the accept edge until the ack cycle inclusive; wb_valid high in the cycle after the ack edge.
- Bus rules:
  - dmem_req, dmem_we, dmem_addr, dmem_wdata and dmem_be are stable while dmem_req=1.
  - dmem_req drops in the cycle after the ack edge.
  - dmem_ack outside ACCESS is ignored.
  - Zero-wait ack (ack in the first ACCESS cycle) is legal.
- Store lanes (off = result[1:0]):
  - Byte: be = 4'b0001 << off; wdata = {4{Data_store[7:0]}}.
  - Half: be = 4'b0011 << (2*result[1]); wdata = {2{Data_store[15:0]}}.
  - Word: be = 4'b1111; wdata = Data_store.
  - Loads: be = 4'b1111, we = 0.
- Load extraction:
  - Byte: rdata[8*off +: 8].
  - Half: rdata[16*result[1] +: 16].
  - Word: rdata as is.
  - Extension: su=1 sign-extends, su=0 zero-extends.
- Write-back select:
  - wb_data per captured wos.
  - A store with wos=01 returns 0.
  - A non-memory op with wos=01 returns 0.
- Reset mid-ACCESS: the request is abandoned immediately (dmem_req=0) and no wb_valid is produced.

Optional Feature:
- Macro: MEM_STAGE_MISALIGN_TRAP_EN.
- Defined:
  - A half access with result[0]=1, or a word access with result[1:0]!=0, skips ACCESS and goes directly IDLE->RESP with no bus request.
  - In RESP: misalign=1 and wb_data=result (faulting address).
- Not defined:
  - The misalign output is tied 0.
  - Misaligned halves use lane result[1].
  - Misaligned words use the aligned word; the low address bits are ignored.

Test Plan:
- Reset: rst=0 mid-ACCESS -> dmem_req=0, wb_valid=0, in_ready=1 next cycle.
- ALU pass-through: opcode=0110011, result=0x100, wos=00 -> no dmem_req; wb_valid one cycle later; wb_data=0x100.
- Signed byte load: result=0x1003, whb=00, su=1, rdata=0x80FF_1234 after 2-cycle ack delay -> dmem_addr=0x1000, wb_data=0xFFFF_FF80, wb_valid 1 cycle after ack.
- Unsigned half load: result=0x2002, whb=01, su=0, rdata=0xBEEF_0000 -> wb_data=0x0000_BEEF.
- Byte store: result=0x3001, Data_store=0x0000_00AB, whb=00 -> dmem_we=1, dmem_be=0010, dmem_wdata=0xABAB_ABAB, stable until ack.
- Misaligned word (macro defined): result=0x4002, whb=10, load -> no dmem_req, misalign=1, wb_data=0x4002; same stimulus with the macro undefined -> dmem_addr=0x4000, misalign=0.

Source files
------------

// File: rtl/mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_stage : RISC-V memory-access stage (req/ack data bus, load align/ext). |
// | Optional: MEM_STAGE_MISALIGN_TRAP_EN traps misaligned half/word accesses.  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module mem_stage #(
   parameter int         AW       = 32,
   parameter logic [6:0] LOAD_OP  = 7'b0000011,
   parameter logic [6:0] STORE_OP = 7'b0100011
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [31:0]   result,
   input  logic [31:0]   Data_store,
   input  logic [31:0]   immOut,
   input  logic [31:0]   PC_4,
   input  logic [6:0]    opcode,
   input  logic          su,
   input  logic [1:0]    whb,
   input  logic [1:0]    wos,
   output logic          dmem_req,
   output logic          dmem_we,
   output logic [AW-1:0] dmem_addr,
   output logic [31:0]   dmem_wdata,
   output logic [3:0]    dmem_be,
   input  logic          dmem_ack,
   input  logic [31:0]   dmem_rdata,
   output logic          wb_valid,
   output logic [31:0]   wb_data,
   output logic          misalign
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [31:0] r_result;
   logic [31:0] r_store;
   logic [31:0] r_imm;
   logic [31:0] r_pc4;
   logic [6:0]  r_opcode;
   logic        r_su;
   logic [1:0]  r_whb;
   logic [1:0]  r_wos;
   logic [31:0] r_rdata;

   logic        w_in_mem;
   logic        w_in_mis;
   logic        w_accept;
   logic        w_is_load;
   logic        w_is_store;
   logic        w_in_access;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load;

   assign w_in_mem    = (opcode == LOAD_OP) || (opcode == STORE_OP);
   assign w_accept    = (r_state == S_IDLE) && in_valid;
   assign w_is_load   = (r_opcode == LOAD_OP);
   assign w_is_store  = (r_opcode == STORE_OP);
   assign w_in_access = (r_state == S_ACCESS);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
   logic r_mis;

   assign w_in_mis = w_in_mem &&
                     (((whb == 2'b01) && result[0]) ||
                      (whb[1] && (result[1:0] != 2'b00)));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mis <= 1'b0;
      end else if (w_accept) begin
         r_mis <= w_in_mis;
      end
   end

   assign misalign = (r_state == S_RESP) && r_mis;
`else
   assign w_in_mis = 1'b0;
   assign misalign = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (in_valid) begin
               w_state_nxt = (w_in_mem && !w_in_mis) ? S_ACCESS : S_RESP;
            end
         end
         S_ACCESS: begin
            if (dmem_ack) begin
               w_state_nxt = S_RESP;
            end
         end
         S_RESP:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_result <= '0;
         r_store  <= '0;
         r_imm    <= '0;
         r_pc4    <= '0;
         r_opcode <= '0;
         r_su     <= 1'b0;
         r_whb    <= '0;
         r_wos    <= '0;
      end else if (w_accept) begin
         r_result <= result;
         r_store  <= Data_store;
         r_imm    <= immOut;
         r_pc4    <= PC_4;
         r_opcode <= opcode;
         r_su     <= su;
         r_whb    <= whb;
         r_wos    <= wos;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rdata <= '0;
      end else if (w_in_access && dmem_ack) begin
         r_rdata <= dmem_rdata;
      end
   end

   // Bus outputs derive only from the captured request, so they hold steady until ack.
   always_comb begin
      w_be    = 4'b1111;
      w_wdata = '0;
      if (w_is_store) begin
         case (r_whb)
            2'b00: begin
               w_be    = 4'b0001 << r_result[1:0];
               w_wdata = {4{r_store[7:0]}};
            end
            2'b01: begin
               w_be    = r_result[1] ? 4'b1100 : 4'b0011;
               w_wdata = {2{r_store[15:0]}};
            end
            default: begin
               w_be    = 4'b1111;
               w_wdata = r_store;
            end
         endcase
      end
   end

   assign dmem_req   = w_in_access;
   assign dmem_we    = w_in_access && w_is_store;
   assign dmem_addr  = w_in_access ? {r_result[AW-1:2], 2'b00} : '0;
   assign dmem_be    = w_in_access ? w_be : 4'b0000;
   assign dmem_wdata = w_in_access ? w_wdata : '0;
   assign in_ready   = (r_state == S_IDLE);
   assign wb_valid   = (r_state == S_RESP);

   always_comb begin
      w_byte = r_rdata[7:0];
      case (r_result[1:0])
         2'b00:   w_byte = r_rdata[7:0];
         2'b01:   w_byte = r_rdata[15:8];
         2'b10:   w_byte = r_rdata[23:16];
         default: w_byte = r_rdata[31:24];
      endcase
      w_half = r_result[1] ? r_rdata[31:16] : r_rdata[15:0];
   end

   always_comb begin
      w_load = r_rdata;
      case (r_whb)
         2'b00:   w_load = r_su ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
         2'b01:   w_load = r_su ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
         default: w_load = r_rdata;
      endcase
   end

   always_comb begin
      wb_data = '0;
      if (r_state == S_RESP) begin
         case (r_wos)
            2'b00:   wb_data = r_result;
            2'b01:   wb_data = w_is_load ? w_load : 32'd0;
            2'b10:   wb_data = r_pc4;
            default: wb_data = r_imm;
         endcase
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
         if (r_mis) begin
            wb_data = r_result;
         end
`endif
      end
   end

endmodule
`default_nettype wire
